draw_arbiter: RTL and testbench
===============================

Name: draw_arbiter

Overview:
Round controller that lets two players share the single free-running decade counter (SEC, 0-9, advancing on the 1 Hz enable) as a digit source. It sequences one round per START: each player latches DIGITS BCD digits from SEC by pressing its button. Simultaneous presses are arbitrated round-robin, and incomplete players are auto-filled on timeout. Its outputs feed the factorization game logic and display.

Parameters:
DIGITS, 2, BCD digits each player draws per round (1..4)
TIMEOUT_S, 10, seconds (EN1HZ ticks) allowed in DRAW before auto-fill (1..15)

Ports:
CLK  in  1  system clock
RST  in  1  synchronous, active-high reset
START  in  1  one-cycle pulse; begins a round
EN1HZ  in  1  one-cycle 1 Hz enable from the shared counter
SEC  in  4  shared decade counter value, 0..9
REQ_1P  in  1  player 1 draw request, one-cycle pulse
REQ_2P  in  1  player 2 draw request, one-cycle pulse
GRANT  out  2  one-hot draw grant pulse, bit0 = 1P, bit1 = 2P
NUM_1P  out  4*DIGITS  player 1 BCD number, first digit most significant
NUM_2P  out  4*DIGITS  player 2 BCD number
BUSY  out  1  high in DRAW
ROUND_DONE  out  1  one-cycle pulse when both players are complete
TIMED_OUT  out  1  high from timeout until next START or RST
SEC_LEFT  out  4  seconds remaining in DRAW; 0 outside DRAW

Behaviour:
- Reset: all outputs 0; state IDLE; round-robin pointer = 1P; digit counters 0.
- States: IDLE, DRAW, FILL, DONE.
- IDLE/DONE: START -> DRAW next cycle. On entry, clear NUM_1P, NUM_2P, digit counts and TIMED_OUT, and set SEC_LEFT = TIMEOUT_S. Requests outside DRAW are ignored.
- START while in DRAW or FILL is ignored.
- DRAW, per cycle:
  - A player is eligible if its REQ is high and its count < DIGITS.
  - If exactly one player is eligible, grant it.
  - If both are eligible, grant the player named by the pointer, then toggle the pointer. The loser's request is dropped; it must press again.
- Grant action, in the same cycle:
  - GRANT bit = 1.
  - NUM_xP <= {NUM_xP[4*DIGITS-5:0], SEC}. The value used is SEC sampled in the grant cycle.
  - count += 1.
  - Latency: REQ in cycle n -> GRANT and updated NUM in cycle n+1 (registered).
- EN1HZ in DRAW: SEC_LEFT decrements, saturating at 0. If SEC_LEFT == 1 on a tick and a player is incomplete, enter FILL and set TIMED_OUT. A grant in the same cycle is still honoured.
- FILL: one auto-grant per cycle to an incomplete player, round-robin when both are incomplete, using the current SEC. REQ inputs are ignored.
- When both counts == DIGITS (from DRAW or FILL): go to DONE, pulse ROUND_DONE for 1 cycle, BUSY = 0. NUM outputs hold until the next START.
- RST mid-round: immediate return to reset values; no ROUND_DONE.
- Arithmetic: counts are 3 bits. SEC values > 9 are latched as-is; the upstream source guarantees 0..9.

Optional Feature:
- Macro: DRAW_NO_LEAD_ZERO_EN.
- Defined: a request for a player's first digit while SEC == 0 is not granted. No GRANT, count unchanged, and the player must retry. In FILL, an auto-grant for a first digit is stalled while SEC == 0. Round-robin still toggles only on actual grants.
- Undefined: zero is accepted in every digit position.

Decomposition:
- Package draw_pkg holds:
  - the state enum (IDLE, DRAW, FILL, DONE)
  - the player index constants P1 = 0, P2 = 1
  - the BCD digit width constant 4
- One natural sub-module, rr_arb2: a 2-requester round-robin arbiter with a priority pointer and one-hot grant. Reused for DRAW and FILL.

Test Plan:
- Reset, START, SEC = 3 with REQ_1P, SEC = 7 with REQ_1P, SEC = 5 with REQ_2P, SEC = 1 with REQ_2P -> NUM_1P = 0x37, NUM_2P = 0x51, one ROUND_DONE pulse, BUSY falls.
- Both REQ in the same cycle three times from reset -> grants 1P, 2P, 1P (pointer alternates); the losing player's count is unchanged.
- START, only 1P completes, 10 EN1HZ ticks -> SEC_LEFT 10→1, then TIMED_OUT = 1 and FILL auto-grants 2P twice on consecutive cycles, then ROUND_DONE.
- REQ while in IDLE, and a third REQ_1P after 1P is complete -> no GRANT, NUMs unchanged.
- RST asserted mid-DRAW after one grant -> all outputs 0 next cycle; a following START begins a clean round.
- With DRAW_NO_LEAD_ZERO_EN: REQ_1P at SEC = 0 for the first digit -> no grant; REQ_1P at SEC = 4 -> grant, NUM_1P low digit = 4.

Source files
------------

// File: rtl/draw_pkg.sv
// Shared types and constants for the two-player draw round controller.
package draw_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DRAW,
        FILL,
        DONE
    } state_t;

    localparam int P1    = 0;
    localparam int P2    = 1;
    localparam int BCD_W = 4;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; pointer flips only when both contend.
module rr_arb2
    import draw_pkg::*;
(
    input  logic       CLK,
    input  logic       RST,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic ptr;

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = ptr ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            ptr <= 1'(P1);
        end else if (req == 2'b11) begin
            ptr <= ~ptr;
        end
    end

endmodule

// File: rtl/draw_arbiter.sv
// Round controller: two players draw BCD digits from a shared decade counter.
// Optional DRAW_NO_LEAD_ZERO_EN refuses a zero as a player's first digit.
module draw_arbiter
    import draw_pkg::*;
#(
    parameter int DIGITS    = 2,
    parameter int TIMEOUT_S = 10
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  START,
    input  logic                  EN1HZ,
    input  logic [3:0]            SEC,
    input  logic                  REQ_1P,
    input  logic                  REQ_2P,
    output logic [1:0]            GRANT,
    output logic [BCD_W*DIGITS-1:0] NUM_1P,
    output logic [BCD_W*DIGITS-1:0] NUM_2P,
    output logic                  BUSY,
    output logic                  ROUND_DONE,
    output logic                  TIMED_OUT,
    output logic [3:0]            SEC_LEFT
);

    localparam int          NW   = BCD_W * DIGITS;
    localparam logic [2:0]  FULL = 3'(DIGITS);

    state_t     state;
    logic [2:0] cnt1;
    logic [2:0] cnt2;
    logic [2:0] cnt1_n;
    logic [2:0] cnt2_n;
    logic [1:0] elig;
    logic [1:0] gnt;
    logic       drawing;
    logic       active;
    logic       lead_ok1;
    logic       lead_ok2;
    logic       all_done;

`ifdef DRAW_NO_LEAD_ZERO_EN
    assign lead_ok1 = !(cnt1 == 3'd0 && SEC == 4'd0);
    assign lead_ok2 = !(cnt2 == 3'd0 && SEC == 4'd0);
`else
    assign lead_ok1 = 1'b1;
    assign lead_ok2 = 1'b1;
`endif

    // In FILL every incomplete player requests automatically.
    always_comb begin
        drawing  = (state == DRAW);
        active   = drawing || (state == FILL);
        elig     = 2'b00;
        elig[P1] = active && (drawing ? REQ_1P : 1'b1)
                   && (cnt1 != FULL) && lead_ok1;
        elig[P2] = active && (drawing ? REQ_2P : 1'b1)
                   && (cnt2 != FULL) && lead_ok2;
        cnt1_n   = cnt1 + 3'(gnt[P1]);
        cnt2_n   = cnt2 + 3'(gnt[P2]);
        all_done = (cnt1_n == FULL) && (cnt2_n == FULL);
    end

    rr_arb2 u_arb (
        .CLK (CLK),
        .RST (RST),
        .req (elig),
        .gnt (gnt)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            cnt1       <= '0;
            cnt2       <= '0;
            GRANT      <= '0;
            NUM_1P     <= '0;
            NUM_2P     <= '0;
            BUSY       <= 1'b0;
            ROUND_DONE <= 1'b0;
            TIMED_OUT  <= 1'b0;
            SEC_LEFT   <= '0;
        end else begin
            GRANT      <= gnt;
            ROUND_DONE <= 1'b0;
            cnt1       <= cnt1_n;
            cnt2       <= cnt2_n;
            if (gnt[P1]) NUM_1P <= NW'({NUM_1P, SEC});
            if (gnt[P2]) NUM_2P <= NW'({NUM_2P, SEC});
            case (state)
                IDLE, DONE: begin
                    if (START) begin
                        state     <= DRAW;
                        BUSY      <= 1'b1;
                        cnt1      <= '0;
                        cnt2      <= '0;
                        NUM_1P    <= '0;
                        NUM_2P    <= '0;
                        TIMED_OUT <= 1'b0;
                        SEC_LEFT  <= 4'(TIMEOUT_S);
                    end
                end
                DRAW: begin
                    if (EN1HZ && SEC_LEFT != 4'd0) begin
                        SEC_LEFT <= SEC_LEFT - 4'd1;
                    end
                    if (all_done) begin
                        state      <= DONE;
                        BUSY       <= 1'b0;
                        ROUND_DONE <= 1'b1;
                        SEC_LEFT   <= '0;
                    end else if (EN1HZ && SEC_LEFT == 4'd1) begin
                        state     <= FILL;
                        BUSY      <= 1'b0;
                        TIMED_OUT <= 1'b1;
                        SEC_LEFT  <= '0;
                    end
                end
                FILL: begin
                    if (all_done) begin
                        state      <= DONE;
                        ROUND_DONE <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_draw_arbiter.sv
// Self-checking bench for draw_arbiter: directed steps then random traffic
// compared against a digit-queue reference model.
module tb_draw_arbiter;

    localparam int DIGITS    = 2;
    localparam int TIMEOUT_S = 10;
    localparam int NW        = 4 * DIGITS;

    logic          CLK = 1'b0;
    logic          RST;
    logic          START;
    logic          EN1HZ;
    logic [3:0]    SEC;
    logic          REQ_1P;
    logic          REQ_2P;
    logic [1:0]    GRANT;
    logic [NW-1:0] NUM_1P;
    logic [NW-1:0] NUM_2P;
    logic          BUSY;
    logic          ROUND_DONE;
    logic          TIMED_OUT;
    logic [3:0]    SEC_LEFT;

    int checks   = 0;
    int failures = 0;

    // Reference model: round phase, digits drawn per player, next favoured player
    int ph;
    int q1[$];
    int q2[$];
    int ptr;
    bit m_to;
    int m_sl;
    int m_gnt;
    bit m_done;

    draw_arbiter #(
        .DIGITS    (DIGITS),
        .TIMEOUT_S (TIMEOUT_S)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .START      (START),
        .EN1HZ      (EN1HZ),
        .SEC        (SEC),
        .REQ_1P     (REQ_1P),
        .REQ_2P     (REQ_2P),
        .GRANT      (GRANT),
        .NUM_1P     (NUM_1P),
        .NUM_2P     (NUM_2P),
        .BUSY       (BUSY),
        .ROUND_DONE (ROUND_DONE),
        .TIMED_OUT  (TIMED_OUT),
        .SEC_LEFT   (SEC_LEFT)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] bcd(input int q[$]);
        int v = 0;
        foreach (q[i]) v = v * 16 + q[i];
        return 32'(v);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model(input bit rst, input bit start, input bit en,
                         input int sec, input bit r1, input bit r2);
        bit w1;
        bit w2;
        int win;
        m_gnt  = 0;
        m_done = 0;
        if (rst) begin
            ph = 0; q1.delete(); q2.delete(); ptr = 0; m_to = 0; m_sl = 0;
            return;
        end
        if (ph == 0 || ph == 3) begin
            if (start) begin
                ph = 1; q1.delete(); q2.delete(); m_to = 0; m_sl = TIMEOUT_S;
            end
            return;
        end
        w1 = (ph == 1 ? r1 : 1'b1) && q1.size() < DIGITS;
        w2 = (ph == 1 ? r2 : 1'b1) && q2.size() < DIGITS;
`ifdef DRAW_NO_LEAD_ZERO_EN
        if (q1.size() == 0 && sec == 0) w1 = 0;
        if (q2.size() == 0 && sec == 0) w2 = 0;
`endif
        if (w1 && w2) begin
            win = ptr;
            ptr = 1 - ptr;
        end else begin
            win = w1 ? 0 : (w2 ? 1 : -1);
        end
        if (win == 0) begin q1.push_back(sec); m_gnt = 1; end
        if (win == 1) begin q2.push_back(sec); m_gnt = 2; end
        if (q1.size() == DIGITS && q2.size() == DIGITS) begin
            ph = 3; m_done = 1; m_sl = 0;
        end else if (ph == 1 && en) begin
            if (m_sl == 1) begin
                ph = 2; m_to = 1; m_sl = 0;
            end else if (m_sl > 0) begin
                m_sl--;
            end
        end
    endtask

    task automatic step(input bit rst, input bit start, input bit en,
                        input int sec, input bit r1, input bit r2);
        RST = rst; START = start; EN1HZ = en;
        SEC = 4'(sec); REQ_1P = r1; REQ_2P = r2;
        @(posedge CLK);
        model(rst, start, en, sec, r1, r2);
        #1;
        chk("grant", 32'(GRANT), 32'(m_gnt));
        chk("num_1p", 32'(NUM_1P), bcd(q1));
        chk("num_2p", 32'(NUM_2P), bcd(q2));
        chk("busy", 32'(BUSY), 32'(ph == 1));
        chk("round_done", 32'(ROUND_DONE), 32'(m_done));
        chk("timed_out", 32'(TIMED_OUT), 32'(m_to));
        chk("sec_left", 32'(SEC_LEFT), 32'(m_sl));
    endtask

    initial begin
        RST = 1'b1; START = 1'b0; EN1HZ = 1'b0;
        SEC = 4'd0; REQ_1P = 1'b0; REQ_2P = 1'b0;

        // reset state
        step(1, 0, 0, 0, 0, 0);
        chk("rst_grant", 32'(GRANT), 32'h0);
        chk("rst_sec_left", 32'(SEC_LEFT), 32'h0);

        // basic round
        step(0, 1, 0, 0, 0, 0);
        chk("start_sec_left", 32'(SEC_LEFT), 32'd10);
        step(0, 0, 0, 3, 1, 0);
        step(0, 0, 0, 7, 1, 0);
        step(0, 0, 0, 5, 0, 1);
        step(0, 0, 0, 1, 0, 1);
        chk("r1_num1", 32'(NUM_1P), 32'h37);
        chk("r1_num2", 32'(NUM_2P), 32'h51);
        chk("r1_done", 32'(ROUND_DONE), 32'h1);
        chk("r1_busy", 32'(BUSY), 32'h0);
        step(0, 0, 0, 2, 0, 0);
        chk("r1_done_pulse", 32'(ROUND_DONE), 32'h0);

        // contention alternates
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 2, 1, 1);
        chk("rr_first", 32'(GRANT), 32'h1);
        step(0, 0, 0, 4, 1, 1);
        chk("rr_second", 32'(GRANT), 32'h2);
        step(0, 0, 0, 6, 1, 1);
        chk("rr_third", 32'(GRANT), 32'h1);
        chk("rr_num2", 32'(NUM_2P), 32'h04);

        // timeout and auto-fill
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 8, 1, 0);
        step(0, 0, 0, 9, 1, 0);
        for (int i = 0; i < 9; i++) step(0, 0, 1, 2, 0, 0);
        chk("to_sec_left_1", 32'(SEC_LEFT), 32'd1);
        step(0, 0, 1, 2, 0, 0);
        chk("to_flag", 32'(TIMED_OUT), 32'h1);
        step(0, 0, 0, 5, 0, 0);
        chk("fill_g1", 32'(GRANT), 32'h2);
        step(0, 0, 0, 6, 0, 0);
        chk("fill_g2", 32'(GRANT), 32'h2);
        chk("fill_num2", 32'(NUM_2P), 32'h56);
        chk("fill_done", 32'(ROUND_DONE), 32'h1);

        // ignored requests
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 4, 1, 1);
        chk("idle_req", 32'(GRANT), 32'h0);
        step(0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 1, 0);
        step(0, 0, 0, 2, 1, 0);
        step(0, 0, 0, 3, 1, 0);
        chk("full_req", 32'(GRANT), 32'h0);
        chk("full_num1", 32'(NUM_1P), 32'h12);

        // reset mid-round
        step(0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 3, 1, 0);
        step(1, 0, 0, 0, 0, 0);
        chk("mid_rst_num1", 32'(NUM_1P), 32'h0);
        step(0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 4, 0, 1);
        chk("clean_num2", 32'(NUM_2P), 32'h04);

        // leading zero handling
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0);
`ifdef DRAW_NO_LEAD_ZERO_EN
        chk("lz_block", 32'(GRANT), 32'h0);
`else
        chk("lz_accept", 32'(GRANT), 32'h1);
`endif
        step(0, 0, 0, 4, 1, 0);
        chk("lz_low", 32'(NUM_1P[3:0]), 32'h4);

        // random traffic
        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(0, 299) == 0,
                 $urandom_range(0, 19) == 0,
                 $urandom_range(0, 2) == 0,
                 int'($urandom_range(0, 9)),
                 $urandom_range(0, 2) == 0,
                 $urandom_range(0, 2) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
